// File: rtl/demux_1xn_stream.sv
// 1-to-N stream demux: one register stage per channel, 1-cycle latency; a stalled channel only blocks words addressed to it.
// Optional per-channel saturating acceptance counters are enabled with macro DEMUX_1XN_CNT_EN.
module demux_1xn_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]      out_valid,
  input  logic [CHANNELS-1:0]      out_ready,
  output logic                     sel_err,
  output logic [CHANNELS*16-1:0]   xfer_cnt
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

  logic                      sel_oob;
  logic                      ch_free;
  logic                      accept;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS-1:0]       valid_q, valid_d;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic                      sel_err_q, sel_err_d;

  always_comb begin
    // Out-of-range selects are always accepted so they can be dropped and flagged.
    sel_oob = ({1'b0, sel} >= CH_LIM);
    ch_free = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) ch_free = !valid_q[k] || out_ready[k];
    end
    in_ready  = !rst && (sel_oob || ch_free);
    accept    = in_valid && in_ready;
    load      = '0;
    valid_d   = valid_q;
    data_d    = data_q;
    for (int k = 0; k < CHANNELS; k++) begin
      load[k] = accept && !sel_oob && (sel == SEL_W'(k));
      if (load[k]) begin
        valid_d[k]                = 1'b1;
        data_d[k*WIDTH +: WIDTH]  = in_data;
      end else if (out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    sel_err_d = accept && sel_oob;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign sel_err   = sel_err_q;

`ifdef DEMUX_1XN_CNT_EN
  logic [CHANNELS*16-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (load[k] && cnt_q[k*16 +: 16] != 16'hFFFF)
        cnt_d[k*16 +: 16] = cnt_q[k*16 +: 16] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Randomised and directed bench for demux_1xn_stream against a per-channel queue-slot model.
module tb_demux_1xn_stream;

`ifdef DEMUX_1XN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        sel_err;
  logic [63:0] xfer_cnt;

  logic [7:0]  d3_in_data;
  logic        d3_in_valid;
  logic        d3_in_ready;
  logic [1:0]  d3_sel;
  logic [23:0] d3_out_data;
  logic [2:0]  d3_out_valid;
  logic [2:0]  d3_out_ready;
  logic        d3_sel_err;
  logic [47:0] d3_xfer_cnt;

  demux_1xn_stream #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .xfer_cnt(xfer_cnt));

  demux_1xn_stream #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .sel(d3_sel), .out_data(d3_out_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .sel_err(d3_sel_err), .xfer_cnt(d3_xfer_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: each channel is a one-entry slot with a saturating word counter.
  logic       m_valid [4];
  logic [7:0] m_data  [4];
  int         m_cnt   [4];
  logic       exp_ready;
  logic       obs_ready;

  function automatic logic [3:0] exp_valid();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_valid[k];
    return r;
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = m_data[k];
    return r;
  endfunction

  function automatic logic [63:0] exp_cnt();
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = CNT_EN ? 16'(m_cnt[k]) : 16'h0;
    return r;
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] ordy);
    logic acc;
    @(negedge clk);
    rst = r; in_valid = v; sel = s; in_data = d; out_ready = ordy;
    #1;
    obs_ready = in_ready;
    exp_ready = !r && (!m_valid[s] || ordy[s]);
    acc = v && exp_ready;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (r) begin
        m_valid[k] = 1'b0; m_data[k] = 8'h0; m_cnt[k] = 0;
      end else if (acc && int'(s) == k) begin
        m_valid[k] = 1'b1; m_data[k] = d;
        if (m_cnt[k] < 65535) m_cnt[k]++;
      end else if (ordy[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 2'd2, 8'hEE, 4'hF);
    cycle(1'b1, 1'b1, 2'd1, 8'hDD, 4'h0);
    checks++; if (obs_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b want=0", obs_ready); end
    checks++; if (out_valid !== 4'h0) begin fails++; $display("FAIL reset_valid got=%h want=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_data got=%h want=0", out_data); end
    checks++; if (sel_err !== 1'b0) begin fails++; $display("FAIL reset_sel_err got=%b want=0", sel_err); end
    checks++; if (xfer_cnt !== 64'h0) begin fails++; $display("FAIL reset_cnt got=%h want=0", xfer_cnt); end
  endtask

  task automatic test_single();
    cycle(1'b0, 1'b1, 2'd2, 8'hA5, 4'hF);
    checks++; if (out_valid !== 4'b0100) begin fails++; $display("FAIL single_valid got=%b want=0100", out_valid); end
    checks++; if (out_data[23:16] !== 8'hA5) begin fails++; $display("FAIL single_data got=%h want=a5", out_data[23:16]); end
    cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    checks++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL single_drain got=%b want=0000", out_valid); end
    checks++; if (out_data[23:16] !== 8'hA5) begin fails++; $display("FAIL single_hold got=%h want=a5", out_data[23:16]); end
  endtask

  task automatic test_stall();
    cycle(1'b0, 1'b1, 2'd1, 8'h11, 4'b1101);
    cycle(1'b0, 1'b1, 2'd1, 8'h22, 4'b1101);
    checks++; if (obs_ready !== 1'b0) begin fails++; $display("FAIL stall_ready got=%b want=0", obs_ready); end
    checks++; if (out_data[15:8] !== 8'h11 || out_valid[1] !== 1'b1) begin
      fails++; $display("FAIL stall_hold got=%h/%b want=11/1", out_data[15:8], out_valid[1]); end
    cycle(1'b0, 1'b1, 2'd3, 8'h33, 4'b0101);
    checks++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL stall_other_ready got=%b want=1", obs_ready); end
    checks++; if (out_valid !== 4'b1010 || out_data[31:24] !== 8'h33 || out_data[15:8] !== 8'h11) begin
      fails++; $display("FAIL stall_other got=%b/%h want=1010/33..11..", out_valid, out_data); end
    cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 2'd0, 8'h77, 4'hF);
    cycle(1'b0, 1'b1, 2'd0, 8'h5A, 4'hF);
    checks++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b want=1", obs_ready); end
    checks++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h5A) begin
      fails++; $display("FAIL b2b_reload got=%b/%h want=1/5a", out_valid[0], out_data[7:0]); end
    cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 1'b1, 2'd0, 8'h10, 4'h0);
    cycle(1'b0, 1'b1, 2'd3, 8'h13, 4'h0);
    checks++; if (out_valid !== 4'b1001) begin fails++; $display("FAIL midrst_pre got=%b want=1001", out_valid); end
    cycle(1'b1, 1'b1, 2'd2, 8'h99, 4'h0);
    checks++; if (obs_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready got=%b want=0", obs_ready); end
    checks++; if (out_valid !== 4'h0 || out_data !== 32'h0 || xfer_cnt !== 64'h0) begin
      fails++; $display("FAIL midrst_clear got=%b/%h/%h want=0/0/0", out_valid, out_data, xfer_cnt); end
    cycle(1'b0, 1'b1, 2'd1, 8'hC3, 4'h0);
    checks++; if (out_valid !== 4'b0010 || out_data !== 32'h0000C300) begin
      fails++; $display("FAIL midrst_resume got=%b/%h want=0010/0000c300", out_valid, out_data); end
    cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
            8'($urandom), 4'($urandom));
      checks++; if (obs_ready !== exp_ready) begin fails++; $display("FAIL rand_ready i=%0d got=%b want=%b", i, obs_ready, exp_ready); end
      checks++; if (out_valid !== exp_valid()) begin fails++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, out_valid, exp_valid()); end
      checks++; if (out_data !== exp_data()) begin fails++; $display("FAIL rand_data i=%0d got=%h want=%h", i, out_data, exp_data()); end
      checks++; if (sel_err !== 1'b0) begin fails++; $display("FAIL rand_sel_err i=%0d got=%b want=0", i, sel_err); end
      checks++; if (xfer_cnt !== exp_cnt()) begin fails++; $display("FAIL rand_cnt i=%0d got=%h want=%h", i, xfer_cnt, exp_cnt()); end
    end
  endtask

  task automatic test_sel_oob();
    @(negedge clk);
    d3_in_valid = 1'b1; d3_sel = 2'd2; d3_in_data = 8'h44; d3_out_ready = 3'b000;
    @(negedge clk);
    d3_sel = 2'd3; d3_in_data = 8'h99;
    #1;
    checks++; if (d3_in_ready !== 1'b1) begin fails++; $display("FAIL oob_ready got=%b want=1", d3_in_ready); end
    @(posedge clk); #1;
    checks++; if (d3_sel_err !== 1'b1) begin fails++; $display("FAIL oob_err got=%b want=1", d3_sel_err); end
    checks++; if (d3_out_valid !== 3'b100 || d3_out_data !== 24'h440000) begin
      fails++; $display("FAIL oob_state got=%b/%h want=100/440000", d3_out_valid, d3_out_data); end
    @(negedge clk);
    d3_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (d3_sel_err !== 1'b0) begin fails++; $display("FAIL oob_pulse got=%b want=0", d3_sel_err); end
  endtask

  task automatic test_saturate();
    cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'hF);
    for (int i = 0; i < 70000; i++) cycle(1'b0, 1'b1, 2'd1, 8'(i), 4'hF);
    checks++; if (xfer_cnt !== exp_cnt()) begin fails++; $display("FAIL sat_model got=%h want=%h", xfer_cnt, exp_cnt()); end
    checks++; if (xfer_cnt[31:16] !== (CNT_EN ? 16'hFFFF : 16'h0)) begin
      fails++; $display("FAIL sat_ch1 got=%h want=%h", xfer_cnt[31:16], CNT_EN ? 16'hFFFF : 16'h0); end
    checks++; if (xfer_cnt[15:0] !== 16'h0 || xfer_cnt[63:32] !== 32'h0) begin
      fails++; $display("FAIL sat_others got=%h want=0", {xfer_cnt[63:32], xfer_cnt[15:0]}); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 2'd0; in_data = 8'h0; out_ready = 4'h0;
    d3_in_valid = 1'b0; d3_sel = 2'd0; d3_in_data = 8'h0; d3_out_ready = 3'h0;
    for (int k = 0; k < 4; k++) begin m_valid[k] = 1'b0; m_data[k] = 8'h0; m_cnt[k] = 0; end
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_sel_oob();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/demux_1xn_stream.md
DEMUX_1XN_STREAM -- requirements
Module: demux_1xn_stream

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the data width in bits.
REQ-002 The block SHALL take parameter CHANNELS, default 4, as the number of output channels, legal range 2..16.
REQ-003 The block SHALL take parameter SEL_W, default $clog2(CHANNELS), as the select width.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port in_data, input, width WIDTH: the data word to route.
REQ-007 The block SHALL have port in_valid, input, width 1: in_data and sel are valid.
REQ-008 The block SHALL have port in_ready, output, width 1: the block accepts the word this cycle.
REQ-009 The block SHALL have port sel, input, width SEL_W: the destination channel index, sampled with in_data.
REQ-010 The block SHALL have port out_data, output, width CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 The block SHALL have port out_valid, output, width CHANNELS: per-channel data valid.
REQ-012 The block SHALL have port out_ready, input, width CHANNELS: per-channel consumer ready.
REQ-013 The block SHALL have port sel_err, output, width 1: one-cycle pulse, an out-of-range sel was consumed.
REQ-014 The block SHALL have port xfer_cnt, output, width CHANNELS*16: per-channel accepted-word counters (see Configuration).

Function
REQ-015 The block SHALL hold one output register stage (data plus valid) per channel; latency from acceptance to out_valid SHALL be exactly 1 cycle.
REQ-016 in_ready SHALL be combinational: 1 when sel >= CHANNELS; otherwise !out_valid[sel] || out_ready[sel].
REQ-017 Acceptance SHALL be defined as in_valid && in_ready on a rising edge.
REQ-018 On acceptance with sel < CHANNELS, channel sel SHALL load in_data and set out_valid[sel]=1; all other channels SHALL hold their state.
REQ-019 A channel with out_valid=1 and out_ready=1 and no load in the same cycle SHALL clear out_valid the next cycle; its out_data SHALL hold its last value.
REQ-020 When a channel drains and reloads in the same cycle, out_valid SHALL stay 1 and out_data SHALL take the new word, with no bubble.
REQ-021 A stalled channel (out_valid=1, out_ready=0) SHALL block only words addressed to it; traffic to other channels SHALL proceed.
REQ-022 out_data and out_valid of a channel SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 On acceptance with sel >= CHANNELS (possible only when CHANNELS is not a power of two), the word SHALL be dropped and sel_err SHALL be 1 for exactly the next cycle.
REQ-024 out_ready on a channel with out_valid=0 SHALL have no effect.

Reset
REQ-025 While rst=1 at a clock edge: out_valid = 0, out_data = 0, sel_err = 0, xfer_cnt = 0.
REQ-026 in_ready SHALL be 0 while rst=1, and no word SHALL be accepted during reset.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words with no partial state retained; the block SHALL be fully operational on the first edge after rst falls.

Configuration
REQ-028 With macro DEMUX_1XN_CNT_EN defined, each channel SHALL have a 16-bit counter that increments on every acceptance to that channel and saturates at 16'hFFFF, exposed on xfer_cnt.
REQ-029 Without DEMUX_1XN_CNT_EN, xfer_cnt SHALL be tied to 0, no counter logic SHALL be instantiated, and all other behaviour SHALL be identical.

Verification (WIDTH=8, CHANNELS=4 unless stated)
REQ-030 Reset then drive sel=2, in_data=8'hA5, in_valid=1 for one cycle, with out_ready=4'b1111 -> next cycle out_valid=4'b0100 and channel 2 data=8'hA5; one cycle later out_valid=0.
REQ-031 out_ready[1]=0, send 8'h11 to channel 1, then 8'h22 to channel 1 -> in_ready=0 on the second word, channel 1 holds 8'h11; send 8'h33 to channel 3 -> accepted, channel 3 valid next cycle.
REQ-032 Channel 0 full with out_ready[0]=1, new word 8'h5A to channel 0 on the same cycle -> out_valid[0] stays 1, data becomes 8'h5A, no gap.
REQ-033 CHANNELS=3, sel=3, in_valid=1 -> in_ready=1, sel_err=1 for one cycle, out_valid unchanged.
REQ-034 With words buffered on channels 0 and 3, assert rst for one cycle -> out_valid=0, out_data=0, xfer_cnt=0 next cycle, in_ready=0 during rst.
REQ-035 DEMUX_1XN_CNT_EN defined, 70000 accepted words to channel 1 -> channel 1 count=16'hFFFF, other counts 0; without the macro, xfer_cnt stays 0.
